// File: rtl/inst_pkg.sv
// Shared types and encoding constants for the instruction encoder.
// Op codes 8-15 are outside op_e and are treated as illegal by the packer.
package inst_pkg;

    typedef enum logic [3:0] {
        LD  = 4'd0,
        SD  = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        ADD = 4'd4,
        SUB = 4'd5,
        BEQ = 4'd6,
        BLT = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_DWORD = 3'b011;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BLT   = 3'b100;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    function automatic logic [31:0] rtype(input logic [6:0] f7,
                                          input logic [4:0] rs2,
                                          input logic [4:0] rs1,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_RTYPE};
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Control, request and instruction-memory write signals of the encoder.
// The slave modport is the encoder's view; master is the driver's view.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [4:0]        req_imm;
    logic              req_dir;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;

    logic              illegal;

    modport slave (
        input  start, base_addr, length,
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_dir,
        input  imem_ready,
        output busy, done, req_ready, imem_we, imem_addr, imem_wdata, illegal
    );

    modport master (
        output start, base_addr, length,
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_dir,
        output imem_ready,
        input  busy, done, req_ready, imem_we, imem_addr, imem_wdata, illegal
    );
endinterface

// File: rtl/inst_pack.sv
// Purely combinational field packer: turns one request into a 32-bit word.
// Unknown op codes produce an all-zero word and raise illegal_o.
module inst_pack
    import inst_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  imm_i,
    input  logic        dir_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        case (op_i)
            LD:  word_o = {7'b0, imm_i, 5'b0, F3_DWORD, rd_i, OPC_LOAD};
            SD:  word_o = {12'b0, rs1_i, F3_DWORD, imm_i, OPC_STORE};
            AND: word_o = rtype(F7_ZERO, rs2_i, rs1_i, F3_AND, rd_i);
            OR:  word_o = rtype(F7_ZERO, rs2_i, rs1_i, F3_OR, rd_i);
            ADD: word_o = rtype(F7_ZERO, rs2_i, rs1_i, F3_ADD, rd_i);
            SUB: word_o = rtype(F7_SUB, rs2_i, rs1_i, F3_ADD, rd_i);
            BEQ: word_o = {6'b0, dir_i, rs2_i, rs1_i, F3_BEQ, imm_i, OPC_BRANCH};
            BLT: word_o = {6'b0, dir_i, rs2_i, rs1_i, F3_BLT, imm_i, OPC_BRANCH};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: encodes accepted requests and writes them to consecutive
// instruction-memory words through a single-entry registered output stage.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_encoder_if.slave bus
);

    state_e            state_q;
    logic [ADDR_W-1:0] length_q;
    logic [ADDR_W-1:0] accepted_q;
    logic [ADDR_W-1:0] accepted_d;
    logic [ADDR_W-1:0] next_addr_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              illegal_q;

    logic              accept;
    logic              drain;
    logic [31:0]       pack_word;
    logic              pack_illegal;

    inst_pack u_pack (
        .op_i      (bus.req_op),
        .rd_i      (bus.req_rd),
        .rs1_i     (bus.req_rs1),
        .rs2_i     (bus.req_rs2),
        .imm_i     (bus.req_imm),
        .dir_i     (bus.req_dir),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    // The stage may refill in the same cycle it drains, giving one word per cycle.
    assign drain         = we_q & bus.imem_ready;
    assign bus.req_ready = (state_q == RUN) && (accepted_q < length_q) && (!we_q || bus.imem_ready);
    assign accept        = bus.req_valid & bus.req_ready;
    assign accepted_d    = accept ? accepted_q + ADDR_W'(1) : accepted_q;

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = ((state_q == RUN) && (length_q == '0)) || ((state_q == DRAIN) && drain);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.illegal    = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            length_q    <= '0;
            accepted_q  <= '0;
            next_addr_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= RUN;
                        length_q    <= bus.length;
                        next_addr_q <= bus.base_addr;
                        accepted_q  <= '0;
                        illegal_q   <= 1'b0;
                    end
                end
                RUN: begin
                    // An empty load has nothing to drain and finishes straight away.
                    if (accepted_d == length_q) begin
                        state_q <= (length_q == '0) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                accepted_q  <= accepted_d;
                next_addr_q <= next_addr_q + ADDR_W'(4);
                we_q        <= 1'b1;
                addr_q      <= next_addr_q;
                wdata_q     <= pack_word;
                if (pack_illegal) begin
                    illegal_q <= 1'b1;
                end
            end else if (drain) begin
                we_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder with hand-computed words.
module tb_inst_encoder;
    import inst_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   writeCount;
    int   doneCount;

    inst_encoder_if #(.ADDR_W(8)) bus ();

    inst_encoder #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed memory writes and done pulses, counted at the active edge.
    always @(posedge clk) begin
        if (bus.imem_we && bus.imem_ready) writeCount++;
        if (bus.done) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] imm, input logic dir);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_imm   = imm;
        bus.req_dir   = dir;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        writeCount = 0;
        doneCount  = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = 8'h00;
        bus.length     = 8'h00;
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_rd     = 5'd0;
        bus.req_rs1    = 5'd0;
        bus.req_rs2    = 5'd0;
        bus.req_imm    = 5'd0;
        bus.req_dir    = 1'b0;
        bus.imem_ready = 1'b0;

        #3;
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_we", 32'(bus.imem_we), 32'h0);
        checkOutput("rst_addr", 32'(bus.imem_addr), 32'h0);
        checkOutput("rst_wdata", bus.imem_wdata, 32'h0);
        checkOutput("rst_illegal", 32'(bus.illegal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-word load at full throughput
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 8'h10; bus.length = 8'd3; bus.imem_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        applyStimulus(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0);
        #1;
        checkOutput("t1_busy", 32'(bus.busy), 32'h1);
        checkOutput("t1_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        checkOutput("t1_w0_we", 32'(bus.imem_we), 32'h1);
        checkOutput("t1_w0_addr", 32'(bus.imem_addr), 32'h10);
        checkOutput("t1_w0_data", bus.imem_wdata, 32'h003100B3);
        applyStimulus(LD, 5'd4, 5'd0, 5'd0, 5'd5, 1'b0);
        @(negedge clk);
        checkOutput("t1_w1_addr", 32'(bus.imem_addr), 32'h14);
        checkOutput("t1_w1_data", bus.imem_wdata, 32'h00503203);
        applyStimulus(BEQ, 5'd0, 5'd1, 5'd2, 5'd8, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        checkOutput("t1_w2_addr", 32'(bus.imem_addr), 32'h18);
        checkOutput("t1_w2_data", bus.imem_wdata, 32'h02208463);
        checkOutput("t1_done", 32'(bus.done), 32'h1);
        checkOutput("t1_drain_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        checkOutput("t1_idle_we", 32'(bus.imem_we), 32'h0);
        checkOutput("t1_idle_done", 32'(bus.done), 32'h0);
        checkOutput("t1_writes", 32'(writeCount), 32'd3);
        checkOutput("t1_dones", 32'(doneCount), 32'd1);

        // Back-pressure: stage holds its word while the memory stalls
        bus.imem_ready = 1'b0;
        bus.start = 1'b1; bus.base_addr = 8'h20; bus.length = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        applyStimulus(SUB, 5'd3, 5'd1, 5'd2, 5'd0, 1'b0);
        #1;
        checkOutput("t2_ready_empty", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        applyStimulus(AND, 5'd5, 5'd6, 5'd7, 5'd0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_stall_we", 32'(bus.imem_we), 32'h1);
            checkOutput("t2_stall_addr", 32'(bus.imem_addr), 32'h20);
            checkOutput("t2_stall_data", bus.imem_wdata, 32'h402081B3);
            checkOutput("t2_stall_ready", 32'(bus.req_ready), 32'h0);
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        #1;
        checkOutput("t2_ready_drain", 32'(bus.req_ready), 32'h1);
        checkOutput("t2_no_write_yet", 32'(writeCount), 32'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        checkOutput("t2_w1_addr", 32'(bus.imem_addr), 32'h24);
        checkOutput("t2_w1_data", bus.imem_wdata, 32'h007372B3);
        checkOutput("t2_done", 32'(bus.done), 32'h1);
        @(negedge clk);
        checkOutput("t2_writes", 32'(writeCount), 32'd5);
        checkOutput("t2_dones", 32'(doneCount), 32'd2);

        // Illegal op writes zero and sets the sticky flag
        bus.start = 1'b1; bus.base_addr = 8'h40; bus.length = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        applyStimulus(4'd12, 5'd1, 5'd1, 5'd1, 5'd1, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        checkOutput("t3_we", 32'(bus.imem_we), 32'h1);
        checkOutput("t3_addr", 32'(bus.imem_addr), 32'h40);
        checkOutput("t3_data", bus.imem_wdata, 32'h0);
        checkOutput("t3_illegal", 32'(bus.illegal), 32'h1);
        checkOutput("t3_done", 32'(bus.done), 32'h1);
        @(negedge clk);
        checkOutput("t3_illegal_sticky", 32'(bus.illegal), 32'h1);

        // Zero-length load; its start also clears illegal
        bus.start = 1'b1; bus.base_addr = 8'h00; bus.length = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checkOutput("t4_illegal_clr", 32'(bus.illegal), 32'h0);
        checkOutput("t4_done", 32'(bus.done), 32'h1);
        checkOutput("t4_busy", 32'(bus.busy), 32'h1);
        checkOutput("t4_we", 32'(bus.imem_we), 32'h0);
        checkOutput("t4_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        checkOutput("t4_done_low", 32'(bus.done), 32'h0);
        checkOutput("t4_idle_busy", 32'(bus.busy), 32'h0);
        checkOutput("t4_we_low", 32'(bus.imem_we), 32'h0);
        checkOutput("t4_writes", 32'(writeCount), 32'd6);
        checkOutput("t4_dones", 32'(doneCount), 32'd4);

        // Address wrap past the top of the byte-address space
        bus.start = 1'b1; bus.base_addr = 8'hFC; bus.length = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        applyStimulus(OR, 5'd2, 5'd3, 5'd4, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("t5_w0_addr", 32'(bus.imem_addr), 32'hFC);
        checkOutput("t5_w0_data", bus.imem_wdata, 32'h0041E133);
        applyStimulus(SD, 5'd0, 5'd5, 5'd0, 5'd9, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        checkOutput("t5_w1_addr", 32'(bus.imem_addr), 32'h00);
        checkOutput("t5_w1_data", bus.imem_wdata, 32'h0002B4A3);
        checkOutput("t5_done", 32'(bus.done), 32'h1);
        @(negedge clk);
        checkOutput("t5_writes", 32'(writeCount), 32'd8);
        checkOutput("t5_dones", 32'(doneCount), 32'd5);

        // Reset during the second of four writes aborts the load
        bus.start = 1'b1; bus.base_addr = 8'h80; bus.length = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        applyStimulus(BLT, 5'd0, 5'd1, 5'd2, 5'd4, 1'b0);
        @(negedge clk);
        checkOutput("t6_w0_addr", 32'(bus.imem_addr), 32'h80);
        checkOutput("t6_w0_data", bus.imem_wdata, 32'h0020C263);
        applyStimulus(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("t6_w1_we", 32'(bus.imem_we), 32'h1);
        checkOutput("t6_w1_addr", 32'(bus.imem_addr), 32'h84);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_we", 32'(bus.imem_we), 32'h0);
        checkOutput("t6_rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("t6_rst_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("t6_rst_done", 32'(bus.done), 32'h0);
        checkOutput("t6_rst_addr", 32'(bus.imem_addr), 32'h0);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_writes", 32'(writeCount), 32'd9);
        checkOutput("t6_dones", 32'(doneCount), 32'd5);
        checkOutput("t6_idle_busy", 32'(bus.busy), 32'h0);
        checkOutput("t6_idle_we", 32'(bus.imem_we), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory byte-address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; latches base_addr and length; begins a program load.
REQ-005 base_addr  input  ADDR_W  byte address of the first word.
REQ-006 length  input  ADDR_W  number of words to write.
REQ-007 busy  output  1  high in RUN.
REQ-008 done  output  1  one-cycle pulse when the load completes.
REQ-009 req_valid  input  1  encode request present.
REQ-010 req_ready  output  1  request accepted when valid&ready.
REQ-011 req_op  input  4  operation code (package enum).
REQ-012 req_rd, req_rs1, req_rs2, req_imm  input  5 each  register and immediate fields.
REQ-013 req_dir  input  1  branch direction.
REQ-014 imem_we  output  1  instruction-memory write strobe.
REQ-015 imem_addr  output  ADDR_W  write address.
REQ-016 imem_wdata  output  32  encoded instruction.
REQ-017 imem_ready  input  1  memory accepts the write when imem_we&imem_ready.
REQ-018 illegal  output  1  sticky flag; an illegal op was encoded since the last start.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN; start in IDLE -> RUN; start outside IDLE ignored.
REQ-020 Encoding, unused bits 0: ld = {7'b0,imm,5'b0,3'b011,rd,7'b0000011}; sd = {12'b0,rs1,3'b011,imm,7'b0100011}.
REQ-021 R-type {f7,rs2,rs1,f3,rd,7'b0110011}: and f7=0 f3=111; or f7=0 f3=110; add f7=0 f3=000; sub f7=0100000 f3=000.
REQ-022 beq/blt = {6'b0,dir,rs2,rs1,f3,imm,7'b1100011}, with f3=000 for beq and 100 for blt.
REQ-023 Op codes 8-15 illegal: encoded word 32'h0, illegal set; the word still counts toward length.
REQ-024 Single-entry registered output stage; a request accepted in cycle T drives imem_we in T+1.
REQ-025 req_ready = RUN & accepted<length & (stage empty | stage draining this cycle); full throughput of one word per cycle while imem_ready=1.
REQ-026 imem_we, imem_addr and imem_wdata hold stable while imem_we&!imem_ready.
REQ-027 Write address = base_addr + 4*index, wrapping modulo 2^ADDR_W.
REQ-028 RUN -> DRAIN when accepted==length; DRAIN -> IDLE on the final write handshake, with done pulsing in that same cycle.
REQ-029 length=0: RUN -> IDLE the cycle after start, done pulses, no writes.
REQ-030 start clears illegal and both counters.

Reset
REQ-031 Reset gives IDLE, busy=0, done=0, req_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, illegal=0, counters=0.
REQ-032 Reset mid-load aborts immediately; no further writes occur and no done pulse is issued.

Structure
REQ-033 Package inst_pkg holds the op enum (LD=0, SD=1, AND=2, OR=3, ADD=4, SUB=5, BEQ=6, BLT=7), opcode/f3/f7 constants and the state enum.
REQ-034 Sub-module inst_pack: purely combinational field packer that produces the word and the illegal bit.

Verification
REQ-035 base=0x10, length=3, ops add(rd1,rs1 2,rs2 3), ld(rd4,imm5), beq(rs1 1,rs2 2,dir1,imm8), imem_ready=1 -> writes 0x10:0x003100B3, 0x14:0x00503203, 0x18:0x02208463; done pulses.
REQ-036 sub rd3,rs1 1,rs2 2 with imem_ready low for 3 cycles -> imem_we held with 0x402081B3 at a stable address; req_ready=0 while the stage is full.
REQ-037 req_op=12 -> writes 32'h0, illegal=1; the next start clears illegal.
REQ-038 length=0 -> done the cycle after start, imem_we never asserted.
REQ-039 base=0xFC, length=2 -> writes at 0xFC then 0x00 (wrap).
REQ-040 rst_n low during the second of four writes -> imem_we=0 asynchronously, IDLE, no done.
